uart_top: RTL and testbench
===========================

// Module: uart_top
// PURPOSE
//   Full-duplex UART with an 8-data-bit, parity, 1-stop frame (11 bits, LSB first).
//   Holds a single-byte transmit buffer and a single-byte receive buffer.
//   Error flags cover parity, framing and overrun.
//   Sits between the host register interface (write/read strobes) and the serial pins.
// PARAMETERS
//   CLKS_PER_BIT  260  clk cycles per serial bit (260 @50MHz ~192 kbaud; 5208 -> 9600 baud)
//   PARITY_ODD    0    0 = even parity, 1 = odd parity (both TX generation and RX check)
// PORTS
//   clk         in   1  system clock, rising-edge
//   rst         in   1  asynchronous, active-low reset
//   write       in   1  one-cycle strobe: load tx_data and start a frame
//   read        in   1  one-cycle strobe: acknowledge received byte
//   tx_data     in   8  byte to transmit
//   rx_data     out  8  last received byte; stable until the next frame completes
//   rx          in   1  serial input, idle high
//   tx          out  1  serial output, idle high
//   txrdy       out  1  1 = transmitter idle, write accepted
//   rxrdy       out  1  1 = unread byte in rx_data
//   parityerr   out  1  parity mismatch on the byte in rx_data
//   framingerr  out  1  stop bit sampled low on the byte in rx_data
//   overrun     out  1  a frame completed while rxrdy was still 1
// BEHAVIOUR
//   Reset (rst=0, async): tx=1, txrdy=1, rxrdy=0, rx_data=0, all error flags=0.
//     Both FSMs go to IDLE and all counters clear.
//   TX FSM states: IDLE -> START -> DATA(8) -> PARITY -> STOP -> IDLE.
//     Each state lasts CLKS_PER_BIT cycles.
//   - Start: write=1 with txrdy=1 latches tx_data.
//     txrdy=0 and tx=0 (start bit) from the next edge.
//   - Data bits go out bit0 first; parity = ^data (even), inverted when PARITY_ODD=1; stop = 1.
//   - txrdy returns to 1 at the end of the stop bit, 11*CLKS_PER_BIT cycles after the accepting edge.
//   - write while txrdy=0 is ignored; no buffering, current frame unaffected.
//   RX path: rx passes through a 2-flop synchronizer.
//   RX FSM states: IDLE -> START -> DATA(8) -> PARITY -> STOP -> IDLE.
//   - A falling edge in IDLE starts a count of CLKS_PER_BIT/2.
//     If rx is still 0 at that point, the start bit is valid; otherwise return to IDLE (glitch reject).
//   - Each later bit is sampled every CLKS_PER_BIT at mid-bit; data is shifted in LSB first.
//   - Frame completes at the mid-stop-bit sample. On that cycle:
//     rx_data <= byte, rxrdy <= 1,
//     parityerr <= (received parity != computed parity),
//     framingerr <= (stop==0),
//     overrun <= rxrdy (old value).
//     The new byte always overwrites the old one.
//   - The byte and flags are stored even when errors are present.
//   - FSM then returns to IDLE and waits for rx high before re-arming, so a low stop does not retrigger.
//   read=1: clears rxrdy, parityerr, framingerr and overrun on the next edge; rx_data is unchanged.
//     read while rxrdy=0 has no effect.
//   read and frame completion on the same edge: completion wins.
//     rxrdy stays 1, flags take the new frame's values, overrun=0.
//   TX and RX are fully independent; they may run simultaneously.
//   Reset mid-frame aborts both FSMs immediately; tx goes high and the partial RX byte is discarded.
// TESTING
//   write 0x55 -> tx shows 0,1,0,1,0,1,0,1,0,0(parity),1 at CLKS_PER_BIT per bit.
//     txrdy is low for 11 bit times, then high.
//   drive rx frame 0x55, parity 0, stop 1 -> rxrdy=1, rx_data=0x55, all error flags 0.
//     Then pulse read -> rxrdy=0, rx_data still 0x55.
//   rx frame 0xA7 with parity bit 0 (expected 1) -> rxrdy=1, rx_data=0xA7, parityerr=1.
//     read clears parityerr.
//   rx frame 0x3C with stop bit 0 -> framingerr=1, rx_data=0x3C.
//   two rx frames 0x11 then 0x22 without read -> rx_data=0x22, overrun=1; read clears overrun.
//   write 0x55, then write 0xFF mid-frame -> 0xFF ignored, frame stays 0x55.
//     Also: rst low mid-frame -> tx=1, txrdy=1 immediately.

Source files
------------

// File: rtl/uart_top.sv
// Full-duplex 8-bit UART with parity and one stop bit.
// Single-byte TX/RX buffers with parity, framing and overrun flags.
module uart_top #(
    parameter int unsigned CLKS_PER_BIT = 260,
    parameter bit          PARITY_ODD   = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       write,
    input  logic       read,
    input  logic [7:0] tx_data,
    output logic [7:0] rx_data,
    input  logic       rx,
    output logic       tx,
    output logic       txrdy,
    output logic       rxrdy,
    output logic       parityerr,
    output logic       framingerr,
    output logic       overrun
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    state_e          tx_st_q;
    logic [CW-1:0]   tx_cnt_q;
    logic [2:0]      tx_bit_q;
    logic [7:0]      tx_sh_q;
    logic            tx_par_q;
    logic            tx_q;
    logic            txrdy_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_st_q  <= S_IDLE;
            tx_cnt_q <= '0;
            tx_bit_q <= '0;
            tx_sh_q  <= '0;
            tx_par_q <= 1'b0;
            tx_q     <= 1'b1;
            txrdy_q  <= 1'b1;
        end else begin
            unique case (tx_st_q)
                S_IDLE: begin
                    if (write) begin
                        tx_sh_q  <= tx_data;
                        tx_par_q <= (^tx_data) ^ PARITY_ODD;
                        tx_cnt_q <= '0;
                        tx_q     <= 1'b0;
                        txrdy_q  <= 1'b0;
                        tx_st_q  <= S_START;
                    end
                end
                S_START: begin
                    if (tx_cnt_q == BIT_END) begin
                        tx_cnt_q <= '0;
                        tx_bit_q <= '0;
                        tx_q     <= tx_sh_q[0];
                        tx_st_q  <= S_DATA;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (tx_cnt_q == BIT_END) begin
                        tx_cnt_q <= '0;
                        tx_sh_q  <= tx_sh_q >> 1;
                        if (tx_bit_q == 3'd7) begin
                            tx_q    <= tx_par_q;
                            tx_st_q <= S_PARITY;
                        end else begin
                            tx_q     <= tx_sh_q[1];
                            tx_bit_q <= tx_bit_q + 1'b1;
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (tx_cnt_q == BIT_END) begin
                        tx_cnt_q <= '0;
                        tx_q     <= 1'b1;
                        tx_st_q  <= S_STOP;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                S_STOP: begin
                    if (tx_cnt_q == BIT_END) begin
                        tx_cnt_q <= '0;
                        txrdy_q  <= 1'b1;
                        tx_st_q  <= S_IDLE;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                default: tx_st_q <= S_IDLE;
            endcase
        end
    end

    assign tx    = tx_q;
    assign txrdy = txrdy_q;

    logic            rx_meta_q;
    logic            rx_sync_q;
    logic            rx_prev_q;
    state_e          rx_st_q;
    logic [CW-1:0]   rx_cnt_q;
    logic [2:0]      rx_bit_q;
    logic [7:0]      rx_sh_q;
    logic            rx_par_q;
    logic [7:0]      rx_data_q;
    logic            rxrdy_q;
    logic            perr_q;
    logic            ferr_q;
    logic            ovr_q;

    // Start detection needs a falling edge, so a low stop bit cannot retrigger.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
            rx_st_q   <= S_IDLE;
            rx_cnt_q  <= '0;
            rx_bit_q  <= '0;
            rx_sh_q   <= '0;
            rx_par_q  <= 1'b0;
            rx_data_q <= '0;
            rxrdy_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
            if (read && rxrdy_q) begin
                rxrdy_q <= 1'b0;
                perr_q  <= 1'b0;
                ferr_q  <= 1'b0;
                ovr_q   <= 1'b0;
            end
            unique case (rx_st_q)
                S_IDLE: begin
                    if (rx_prev_q && !rx_sync_q) begin
                        rx_cnt_q <= '0;
                        rx_st_q  <= S_START;
                    end
                end
                S_START: begin
                    if (rx_cnt_q == HALF_END) begin
                        rx_cnt_q <= '0;
                        rx_bit_q <= '0;
                        rx_st_q  <= rx_sync_q ? S_IDLE : S_DATA;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (rx_cnt_q == BIT_END) begin
                        rx_cnt_q <= '0;
                        rx_sh_q  <= {rx_sync_q, rx_sh_q[7:1]};
                        if (rx_bit_q == 3'd7) begin
                            rx_st_q <= S_PARITY;
                        end else begin
                            rx_bit_q <= rx_bit_q + 1'b1;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (rx_cnt_q == BIT_END) begin
                        rx_cnt_q <= '0;
                        rx_par_q <= rx_sync_q;
                        rx_st_q  <= S_STOP;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                S_STOP: begin
                    if (rx_cnt_q == BIT_END) begin
                        rx_cnt_q  <= '0;
                        rx_data_q <= rx_sh_q;
                        rxrdy_q   <= 1'b1;
                        perr_q    <= rx_par_q != ((^rx_sh_q) ^ PARITY_ODD);
                        ferr_q    <= ~rx_sync_q;
                        ovr_q     <= rxrdy_q & ~read;
                        rx_st_q   <= S_IDLE;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                default: rx_st_q <= S_IDLE;
            endcase
        end
    end

    assign rx_data    = rx_data_q;
    assign rxrdy      = rxrdy_q;
    assign parityerr  = perr_q;
    assign framingerr = ferr_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_uart_top.sv
// Scoreboard bench for uart_top: serial TX decoder and RX buffer monitor
// compare against hand-computed frames queued by the stimulus.
module tb_uart_top;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       write = 1'b0;
    logic       read = 1'b0;
    logic [7:0] tx_data = '0;
    logic [7:0] rx_data;
    logic       rx = 1'b1;
    logic       tx;
    logic       txrdy;
    logic       rxrdy;
    logic       parityerr;
    logic       framingerr;
    logic       overrun;

    int n_cmp = 0;
    int n_bad = 0;
    bit tx_mon_en = 1'b1;

    logic [10:0] tx_exp[$];
    logic [10:0] rx_exp[$];

    uart_top #(.CLKS_PER_BIT(CPB), .PARITY_ODD(1'b0)) dut (
        .clk       (clk),
        .rst       (rst),
        .write     (write),
        .read      (read),
        .tx_data   (tx_data),
        .rx_data   (rx_data),
        .rx        (rx),
        .tx        (tx),
        .txrdy     (txrdy),
        .rxrdy     (rxrdy),
        .parityerr (parityerr),
        .framingerr(framingerr),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // TX monitor: decode serial frames, bit0 = start ... bit10 = stop.
    initial begin
        logic        prev;
        logic [10:0] fr;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (rst && tx_mon_en && prev && !tx) begin
                repeat (CPB / 2) @(negedge clk);
                fr[0] = tx;
                for (int i = 1; i < 11; i++) begin
                    repeat (CPB) @(negedge clk);
                    fr[i] = tx;
                end
                if (tx_exp.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL tx_unexpected: got %0h expected none", fr);
                end else begin
                    check("tx_frame", 32'(fr), 32'(tx_exp.pop_front()));
                end
            end
            prev = tx;
        end
    end

    // RX monitor: any new frame presented in the buffer is checked.
    initial begin
        logic [11:0] prev_s;
        logic [11:0] cur_s;
        prev_s = '0;
        forever begin
            @(negedge clk);
            cur_s = {rxrdy, rx_data, parityerr, framingerr, overrun};
            if (rst && rxrdy && cur_s != prev_s) begin
                if (rx_exp.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL rx_unexpected: got %0h expected none",
                             cur_s[10:0]);
                end else begin
                    check("rx_frame", 32'(cur_s[10:0]),
                          32'(rx_exp.pop_front()));
                end
            end
            prev_s = cur_s;
        end
    end

    task automatic tx_send(input logic [7:0] d, input logic [10:0] frame,
                           input bit poke);
        int rest;
        tx_exp.push_back(frame);
        @(negedge clk);
        tx_data = d;
        write   = 1'b1;
        @(posedge clk);
        #1 write = 1'b0;
        check("txrdy_busy", 32'(txrdy), 32'd0);
        rest = 11 * CPB - 1;
        if (poke) begin
            repeat (3 * CPB) @(posedge clk);
            #1;
            tx_data = 8'hFF;
            write   = 1'b1;
            @(posedge clk);
            #1 write = 1'b0;
            check("txrdy_poke", 32'(txrdy), 32'd0);
            rest = rest - 3 * CPB - 1;
        end
        repeat (rest) @(posedge clk);
        #1 check("txrdy_last", 32'(txrdy), 32'd0);
        @(posedge clk);
        #1 check("txrdy_done", 32'(txrdy), 32'd1);
    endtask

    task automatic rx_send(input logic [7:0] d, input logic par,
                           input logic stp, input logic [10:0] exp);
        logic [10:0] bits;
        bits = {stp, par, d, 1'b0};
        if (exp != '1) rx_exp.push_back(exp);
        for (int i = 0; i < 11; i++) begin
            rx = bits[i];
            repeat (CPB) @(posedge clk);
        end
        rx = 1'b1;
        repeat (2 * CPB) @(posedge clk);
    endtask

    task automatic do_read();
        @(negedge clk);
        read = 1'b1;
        @(posedge clk);
        #1 read = 1'b0;
    endtask

    initial begin
        #23;
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_txrdy", 32'(txrdy), 32'd1);
        check("rst_rxrdy", 32'(rxrdy), 32'd0);
        check("rst_rxdata", 32'(rx_data), 32'd0);
        check("rst_flags", 32'({parityerr, framingerr, overrun}), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(posedge clk);

        tx_send(8'h55, 11'h4AA, 1'b0);
        repeat (CPB) @(posedge clk);

        rx_send(8'h55, 1'b0, 1'b1, {8'h55, 3'b000});
        do_read();
        check("read_rxrdy", 32'(rxrdy), 32'd0);
        check("read_keep", 32'(rx_data), 32'h55);

        rx_send(8'hA7, 1'b0, 1'b1, {8'hA7, 3'b100});
        check("perr_set", 32'(parityerr), 32'd1);
        do_read();
        check("perr_clr", 32'(parityerr), 32'd0);

        fork
            rx_send(8'h3C, 1'b0, 1'b0, {8'h3C, 3'b010});
            tx_send(8'hC3, 11'h586, 1'b0);
        join
        check("ferr_set", 32'(framingerr), 32'd1);
        do_read();
        check("ferr_clr", 32'(framingerr), 32'd0);

        rx_send(8'h11, 1'b0, 1'b1, {8'h11, 3'b000});
        rx_send(8'h22, 1'b0, 1'b1, {8'h22, 3'b001});
        do_read();
        check("ovr_clr", 32'({rxrdy, overrun}), 32'd0);
        check("ovr_keep", 32'(rx_data), 32'h22);

        do_read();
        check("idle_read", 32'({rxrdy, rx_data}), 32'h022);

        tx_send(8'h55, 11'h4AA, 1'b1);
        repeat (CPB) @(posedge clk);

        tx_mon_en = 1'b0;
        @(negedge clk);
        tx_data = 8'h00;
        write   = 1'b1;
        @(posedge clk);
        #1 write = 1'b0;
        repeat (4 * CPB) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("midrst_tx", 32'(tx), 32'd1);
        check("midrst_txrdy", 32'(txrdy), 32'd1);
        check("midrst_rx", 32'({rxrdy, rx_data}), 32'd0);
        repeat (3) @(posedge clk);
        rst = 1'b1;
        repeat (4) @(posedge clk);

        check("tx_queue_empty", 32'(tx_exp.size()), 32'd0);
        check("rx_queue_empty", 32'(rx_exp.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
